pipeline_debug_ctrl: RTL and testbench

//  Debug/sequencing controller for the 5-stage MIPS pipeline. Takes byte commands from a

---
 rtl/pipeline_debug_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
// UART-driven debug controller for the 5-stage MIPS pipeline: program load,
// run/step control, and a PC/register/memory dump back to the transmitter.
module pipeline_debug_ctrl #(
    parameter int                 INST_SZ    = 32,
    parameter int                 PC_SZ      = 32,
    parameter int                 REG_SZ     = 5,
    parameter int                 MEM_SZ     = 10,
    parameter logic [INST_SZ-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_pipe_reset,
    output logic               o_write,
    output logic               o_enable,
    output logic [INST_SZ-1:0] o_instruction,
    output logic [REG_SZ-1:0]  o_debug_addr,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic               i_halt,
    output logic               o_halted
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam int                  NWORDS    = 2 ** REG_SZ;
    localparam int                  DCNT_W    = REG_SZ + 2;
    localparam logic [DCNT_W-1:0]   NREG_LAST = DCNT_W'(NWORDS);
    localparam logic [DCNT_W-1:0]   DUMP_LAST = DCNT_W'(2 * NWORDS);
    localparam logic [MEM_SZ:0]     WORD_MAX  = (MEM_SZ + 1)'(2 ** MEM_SZ);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, RUN, STEP, DUMP_ADDR, DUMP_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [MEM_SZ:0]     word_cnt_q, word_cnt_d;
    logic [INST_SZ-1:0]  instr_q, instr_d;
    logic [DCNT_W-1:0]   dump_cnt_q, dump_cnt_d;
    logic [REG_SZ-1:0]   debug_addr_q, debug_addr_d;
    logic [INST_SZ-1:0]  shift_q, shift_d;
    logic                addr_wait_q, addr_wait_d;
    logic                halted_q, halted_d;
    logic                pipe_reset_q, pipe_reset_d;
    logic                start_dump;
    logic [INST_SZ-1:0]  dump_word;

    // Word 0 is the PC, words 1..NWORDS are registers, the rest data memory.
    always_comb begin
        if (dump_cnt_q == '0)
            dump_word = INST_SZ'(i_pc);
        else if (dump_cnt_q <= NREG_LAST)
            dump_word = i_reg;
        else
            dump_word = i_mem;
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        instr_d      = instr_q;
        dump_cnt_d   = dump_cnt_q;
        debug_addr_d = debug_addr_q;
        shift_d      = shift_q;
        addr_wait_d  = addr_wait_q;
        halted_d     = halted_q;
        pipe_reset_d = 1'b0;
        start_dump   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d      = LOAD;
                            pipe_reset_d = 1'b1;
                            byte_cnt_d   = '0;
                            word_cnt_d   = '0;
                            halted_d     = 1'b0;
                        end
                        CMD_CONT, CMD_STEP: begin
                            if (halted_q)
                                start_dump = 1'b1;
                            else if (i_rx_data == CMD_CONT)
                                state_d = RUN;
                            else
                                state_d = STEP;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                if (i_rx_valid) begin
                    instr_d    = {instr_q[INST_SZ-9:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3)
                        state_d = WRITE;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + (MEM_SZ + 1)'(1);
                if (instr_q == HALT_INSTR || word_cnt_d == WORD_MAX)
                    state_d = IDLE;
                else
                    state_d = LOAD;
            end
            RUN: begin
                if (i_halt) begin
                    halted_d   = 1'b1;
                    start_dump = 1'b1;
                end
            end
            STEP: begin
                halted_d   = halted_q | i_halt;
                start_dump = 1'b1;
            end
            // One settle cycle lets the pipeline's debug read path follow o_debug_addr.
            DUMP_ADDR: begin
                if (!addr_wait_q) begin
                    addr_wait_d = 1'b1;
                end else begin
                    addr_wait_d = 1'b0;
                    shift_d     = dump_word;
                    byte_cnt_d  = '0;
                    state_d     = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                if (i_tx_ready) begin
                    shift_d    = {shift_q[INST_SZ-9:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (dump_cnt_q == DUMP_LAST) begin
                            state_d = IDLE;
                        end else begin
                            // Old count doubles as the next address and wraps between phases.
                            dump_cnt_d   = dump_cnt_q + DCNT_W'(1);
                            debug_addr_d = dump_cnt_q[REG_SZ-1:0];
                            state_d      = DUMP_ADDR;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_dump) begin
            state_d      = DUMP_ADDR;
            dump_cnt_d   = '0;
            debug_addr_d = '0;
            addr_wait_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            instr_q      <= '0;
            dump_cnt_q   <= '0;
            debug_addr_q <= '0;
            shift_q      <= '0;
            addr_wait_q  <= 1'b0;
            halted_q     <= 1'b0;
            pipe_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            instr_q      <= instr_d;
            dump_cnt_q   <= dump_cnt_d;
            debug_addr_q <= debug_addr_d;
            shift_q      <= shift_d;
            addr_wait_q  <= addr_wait_d;
            halted_q     <= halted_d;
            pipe_reset_q <= pipe_reset_d;
        end
    end

    assign o_tx_data     = shift_q[INST_SZ-1 -: 8];
    assign o_tx_valid    = (state_q == DUMP_SEND);
    assign o_write       = (state_q == WRITE);
    assign o_enable      = (state_q == RUN) || (state_q == STEP);
    assign o_pipe_reset  = pipe_reset_q;
    assign o_instruction = instr_q;
    assign o_debug_addr  = debug_addr_q;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: load, step, run-to-halt, back-pressured dump,
// ignored commands and reset during load, with byte/word scoreboards.
module tb_pipeline_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [31:0] pc;
    logic        halt;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        pipe_reset;
    logic        wr;
    logic        enable;
    logic [31:0] instr;
    logic [4:0]  dbg_addr;
    logic [31:0] reg_word;
    logic [31:0] mem_word;
    logic        halted;

    int n_run = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int wr_cnt = 0;
    int prst_cnt = 0;
    int tx_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wr[$];
    logic        stalled = 1'b0;
    logic [7:0]  stall_data;

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_model(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] mem_model(input int k);
        return 32'h8000_0000 ^ (32'(k) * 32'h0103_0507);
    endfunction

    // Stand-in for the pipeline's register file and data memory read ports.
    assign reg_word = reg_model(int'(dbg_addr));
    assign mem_word = mem_model(int'(dbg_addr));

    pipeline_debug_ctrl dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .i_tx_ready    (tx_ready),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .o_pipe_reset  (pipe_reset),
        .o_write       (wr),
        .o_enable      (enable),
        .o_instruction (instr),
        .o_debug_addr  (dbg_addr),
        .i_pc          (pc),
        .i_reg         (reg_word),
        .i_mem         (mem_word),
        .i_halt        (halt),
        .o_halted      (halted)
    );

    // Output monitor: pulse counters plus write and transmit scoreboards.
    always @(negedge clk) begin
        logic [31:0] ew;
        logic [7:0]  eb;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (enable) en_cnt++;
            if (pipe_reset) prst_cnt++;
            if (wr) begin
                wr_cnt++;
                n_run++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got word %h, required no write", instr);
                end else begin
                    ew = exp_wr.pop_front();
                    if (instr !== ew) begin
                        n_fail++;
                        $display("FAIL write_word: got %h, required %h", instr, ew);
                    end
                end
            end
            if (tx_valid) begin
                if (stalled) begin
                    n_run++;
                    if (tx_data !== stall_data) begin
                        n_fail++;
                        $display("FAIL tx_stable: got %h, required %h", tx_data, stall_data);
                    end
                end
                if (tx_ready) begin
                    tx_cnt++;
                    n_run++;
                    stalled = 1'b0;
                    if (exp_tx.size() == 0) begin
                        n_fail++;
                        $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
                    end else begin
                        eb = exp_tx.pop_front();
                        if (tx_data !== eb) begin
                            n_fail++;
                            $display("FAIL tx_byte %0d: got %h, required %h", tx_cnt, tx_data, eb);
                        end
                    end
                end else begin
                    stalled    = 1'b1;
                    stall_data = tx_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] p);
        push_word(p);
        for (int k = 0; k < 32; k++) push_word(reg_model(k));
        for (int k = 0; k < 32; k++) push_word(mem_model(k));
    endtask

    task automatic drain(input string name, input bit toggle);
        int cyc = 0;
        while (exp_tx.size() != 0 && cyc < 4000) begin
            @(posedge clk);
            #1;
            if (toggle) tx_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        tx_ready = 1'b1;
        n_run++;
        if (exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_tx.size());
            exp_tx.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({tx_valid, pipe_reset, wr, enable, halted} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {tx_valid, pipe_reset, wr, enable, halted});
        end
        n_run++;
        if ({tx_data, instr, dbg_addr} !== 45'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h, required 0", tx_data, instr, dbg_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_program(input logic [31:0] words[$]);
        send_byte(8'h4C);
        foreach (words[i]) begin
            exp_wr.push_back(words[i]);
            for (int b = 3; b >= 0; b--) send_byte(words[i][8*b +: 8]);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        logic [31:0] prog[$];
        prog = '{32'h0000_0001, 32'h2001_0005, 32'hFFFF_FFFF};
        en_cnt = 0; wr_cnt = 0; prst_cnt = 0;
        load_program(prog);
        send_byte(8'h00);
        repeat (4) @(posedge clk);
        #1;
        n_run++;
        if (wr_cnt !== 3) begin
            n_fail++;
            $display("FAIL load_writes: got %0d, required 3", wr_cnt);
        end
        n_run++;
        if (prst_cnt !== 1) begin
            n_fail++;
            $display("FAIL load_pipe_reset: got %0d, required 1", prst_cnt);
        end
        n_run++;
        if (en_cnt !== 0) begin
            n_fail++;
            $display("FAIL load_enable: got %0d, required 0", en_cnt);
        end
        n_run++;
        if (exp_wr.size() !== 0) begin
            n_fail++;
            $display("FAIL load_words_left: got %0d, required 0", exp_wr.size());
        end
    endtask

    task automatic test_step();
        en_cnt = 0; tx_cnt = 0;
        pc = 32'h0040_0010;
        push_dump(pc);
        send_byte(8'h53);
        drain("step", 1'b0);
        n_run++;
        if (en_cnt !== 1) begin
            n_fail++;
            $display("FAIL step_enable: got %0d, required 1", en_cnt);
        end
        n_run++;
        if (tx_cnt !== 260) begin
            n_fail++;
            $display("FAIL step_bytes: got %0d, required 260", tx_cnt);
        end
        n_run++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL step_halted: got %b, required 0", halted);
        end
    endtask

    task automatic test_run_halt();
        int k = 0;
        int cyc = 0;
        en_cnt = 0; tx_cnt = 0;
        pc = 32'hBFC0_0024;
        push_dump(pc);
        send_byte(8'h43);
        while (k < 10 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (enable) k++;
        end
        halt = 1'b1;
        @(posedge clk);
        #1;
        halt = 1'b0;
        drain("run", 1'b0);
        n_run++;
        if (en_cnt !== 10) begin
            n_fail++;
            $display("FAIL run_enable: got %0d, required 10", en_cnt);
        end
        n_run++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL run_halted: got %b, required 1", halted);
        end
        n_run++;
        if (tx_cnt !== 260) begin
            n_fail++;
            $display("FAIL run_bytes: got %0d, required 260", tx_cnt);
        end
        en_cnt = 0; tx_cnt = 0;
        pc = 32'h1234_5678;
        push_dump(pc);
        send_byte(8'h53);
        drain("halted_step", 1'b0);
        n_run++;
        if (en_cnt !== 0) begin
            n_fail++;
            $display("FAIL halted_step_enable: got %0d, required 0", en_cnt);
        end
        n_run++;
        if (tx_cnt !== 260 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halted_step_dump: got %0d bytes halted=%b, required 260 halted=1",
                     tx_cnt, halted);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] prog[$];
        prog = '{32'hFFFF_FFFF};
        load_program(prog);
        n_run++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_halted: got %b, required 0", halted);
        end
        tx_cnt = 0;
        pc = 32'hA5C3_0F96;
        push_dump(pc);
        send_byte(8'h53);
        drain("backpressure", 1'b1);
        n_run++;
        if (tx_cnt !== 260) begin
            n_fail++;
            $display("FAIL backpressure_bytes: got %0d, required 260", tx_cnt);
        end
    endtask

    task automatic test_ignore();
        en_cnt = 0; wr_cnt = 0; prst_cnt = 0; tx_cnt = 0;
        send_byte(8'h58);
        repeat (10) @(posedge clk);
        #1;
        n_run++;
        if (en_cnt + wr_cnt + prst_cnt + tx_cnt !== 0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_x: got en=%0d wr=%0d prst=%0d tx=%0d, required all 0",
                     en_cnt, wr_cnt, prst_cnt, tx_cnt);
        end
        pc = 32'h0BAD_F00D;
        push_dump(pc);
        send_byte(8'h53);
        repeat (20) @(posedge clk);
        send_byte(8'h53);
        drain("mid_dump", 1'b0);
        repeat (20) @(posedge clk);
        #1;
        n_run++;
        if (tx_cnt !== 260) begin
            n_fail++;
            $display("FAIL mid_dump_bytes: got %0d, required 260", tx_cnt);
        end
        n_run++;
        if (en_cnt !== 1) begin
            n_fail++;
            $display("FAIL mid_dump_enable: got %0d, required 1", en_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] prog[$];
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        n_run++;
        if (instr !== 32'hFFFF_1234) begin
            n_fail++;
            $display("FAIL partial_load: got %h, required ffff1234", instr);
        end
        rst_n = 1'b0;
        #2;
        n_run++;
        if ({tx_valid, pipe_reset, wr, enable, halted, tx_data, instr, dbg_addr} !== 50'b0) begin
            n_fail++;
            $display("FAIL async_reset: got instr=%h addr=%h ctrl=%b, required 0",
                     instr, dbg_addr, {tx_valid, pipe_reset, wr, enable, halted});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_cnt = 0; prst_cnt = 0;
        prog = '{32'h1122_3344, 32'hFFFF_FFFF};
        load_program(prog);
        n_run++;
        if (wr_cnt !== 2 || exp_wr.size() !== 0) begin
            n_fail++;
            $display("FAIL reload_writes: got %0d (left %0d), required 2 (left 0)",
                     wr_cnt, exp_wr.size());
        end
        n_run++;
        if (prst_cnt !== 1) begin
            n_fail++;
            $display("FAIL reload_pipe_reset: got %0d, required 1", prst_cnt);
        end
    endtask

    initial begin
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        pc       = 32'h0;
        halt     = 1'b0;
        test_reset();
        test_load();
        test_step();
        test_run_halt();
        test_backpressure();
        test_ignore();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
